// File: rtl/phy_tx_stim_gen.sv
// phy_tx_stim_gen
// ---------------
// Repeatable N-lane stimulus generator for the phy_tx path, plus a bit-for-bit
// comparator of the serial lane outputs from the conductual and structural
// descriptions.
//
// Timing: a 2f slot is four clk_8f cycles. A free-running 2-bit phase counter
// marks the slots. Each lane then runs its own schedule of bursts and gaps,
// delayed by lane*SKEW slots.
//
// Optional feature macro: PHY_TX_STIM_CHECK_EN
//   defined   -> the comparator drives mismatch_mask and mismatch_count.
//   undefined -> the comparator is removed, both mismatch outputs are tied to
//                0, and ser_a/ser_b are ignored.
//
// Ports
//   clk_8f          in   fastest clock; all logic runs on its rising edge
//   reset           in   synchronous, active-high
//   start           in   run request, level-sampled in IDLE/DONE
//   enable          out  high while RUN
//   validin         out  [LANES]        per-lane valid
//   entrada         out  [LANES*WIDTH]  per-lane data, lane i at [i*WIDTH +: WIDTH]
//   slot_stb        out  high on the last clk_8f cycle of each slot
//   done            out  schedule complete, sticky until restart/reset
//   ser_a, ser_b    in   [LANES] serial lane outputs of the two descriptions
//   mismatch_mask   out  [LANES]        sticky per-lane mismatch flags
//   mismatch_count  out  [LANES*16]     saturating per-lane mismatch counters
module phy_tx_stim_gen #(
  parameter int LANES       = 2,
  parameter int WIDTH       = 8,
  parameter int BURST_LEN   = 4,
  parameter int GAP_LEN     = 3,
  parameter int NUM_BURSTS  = 2,
  parameter int SKEW        = 1,
  parameter int SEED        = 0,
  parameter int SEED_STEP   = 'hEF,
  parameter int CHECK_DELAY = 8
) (
  input  logic                   clk_8f,
  input  logic                   reset,
  input  logic                   start,
  output logic                   enable,
  output logic [LANES-1:0]       validin,
  output logic [LANES*WIDTH-1:0] entrada,
  output logic                   slot_stb,
  output logic                   done,
  input  logic [LANES-1:0]       ser_a,
  input  logic [LANES-1:0]       ser_b,
  output logic [LANES-1:0]       mismatch_mask,
  output logic [LANES*16-1:0]    mismatch_count
);

  localparam int PERIOD    = BURST_LEN + GAP_LEN;
  localparam int LAST_SLOT = NUM_BURSTS * PERIOD + (LANES - 1) * SKEW - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  phase;
  logic        start_pending;
  logic [15:0] slot_idx;
  logic        go, step, finish;

  // Schedule state of each lane for the slot that is driven next.
  logic [15:0] wait_cnt [LANES];
  logic [15:0] pos      [LANES];
  logic [15:0] bcnt     [LANES];
  logic [LANES-1:0] fin;

  logic [15:0] cur_wait [LANES];
  logic [15:0] cur_pos  [LANES];
  logic [15:0] cur_bcnt [LANES];
  logic [LANES-1:0] cur_fin;
  logic [15:0] nxt_wait [LANES];
  logic [15:0] nxt_pos  [LANES];
  logic [15:0] nxt_bcnt [LANES];
  logic [LANES-1:0] nxt_fin;
  logic [LANES-1:0] lane_act;
  logic [WIDTH-1:0] lane_base [LANES];

  function automatic logic [WIDTH-1:0] lane_seed(input int i);
    return WIDTH'(SEED + i * SEED_STEP);
  endfunction

  // Slot sequencing and start handshake. go enters RUN on a slot boundary.
  // step advances to the next slot. finish leaves RUN after the last slot.
  always_comb begin
    state_next = state;
    go         = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (slot_stb && start_pending) begin
          state_next = RUN;
          go         = 1'b1;
        end
      end
      RUN: begin
        if (slot_stb) begin
          if (slot_idx == 16'(LAST_SLOT)) begin
            state_next = DONE;
            finish     = 1'b1;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-lane schedule. Each lane first counts down its skew. It then walks a
  // position counter through burst+gap and counts bursts, so no divider is
  // needed. On entry to RUN the lane starts from its initial state and its
  // seed instead of the registered values.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      cur_wait[i]  = go ? 16'(i * SKEW) : wait_cnt[i];
      cur_pos[i]   = go ? 16'd0 : pos[i];
      cur_bcnt[i]  = go ? 16'd0 : bcnt[i];
      cur_fin[i]   = go ? 1'b0 : fin[i];
      lane_base[i] = go ? lane_seed(i) : entrada[i*WIDTH +: WIDTH];
      lane_act[i]  = (cur_wait[i] == 16'd0) && !cur_fin[i] &&
                     (cur_pos[i] < 16'(BURST_LEN));
      nxt_wait[i]  = cur_wait[i];
      nxt_pos[i]   = cur_pos[i];
      nxt_bcnt[i]  = cur_bcnt[i];
      nxt_fin[i]   = cur_fin[i];
      if (cur_wait[i] != 16'd0) begin
        nxt_wait[i] = cur_wait[i] - 16'd1;
      end else if (!cur_fin[i]) begin
        if (cur_pos[i] == 16'(PERIOD - 1)) begin
          nxt_pos[i]  = 16'd0;
          nxt_bcnt[i] = cur_bcnt[i] + 16'd1;
          if (cur_bcnt[i] == 16'(NUM_BURSTS - 1)) begin
            nxt_fin[i] = 1'b1;
          end
        end else begin
          nxt_pos[i] = cur_pos[i] + 16'd1;
        end
      end
    end
  end

  // Registers for the phase, the FSM and all slot outputs. Slot outputs update
  // only on the edge where slot_stb is high. slot_stb is registered one cycle
  // ahead from the phase count.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state         <= IDLE;
      phase         <= 2'd0;
      slot_stb      <= 1'b0;
      start_pending <= 1'b0;
      slot_idx      <= 16'd0;
      enable        <= 1'b0;
      validin       <= '0;
      done          <= 1'b0;
      fin           <= '0;
      for (int i = 0; i < LANES; i++) begin
        entrada[i*WIDTH +: WIDTH] <= lane_seed(i);
        wait_cnt[i]               <= 16'd0;
        pos[i]                    <= 16'd0;
        bcnt[i]                   <= 16'd0;
      end
    end else begin
      phase    <= phase + 2'd1;
      slot_stb <= (phase == 2'd2);
      state    <= state_next;
      if (go) begin
        start_pending <= 1'b0;
      end else if (start && state != RUN) begin
        start_pending <= 1'b1;
      end
      if (go || step) begin
        slot_idx <= go ? 16'd0 : slot_idx + 16'd1;
        enable   <= 1'b1;
        done     <= 1'b0;
        validin  <= lane_act;
        fin      <= nxt_fin;
        for (int i = 0; i < LANES; i++) begin
          wait_cnt[i] <= nxt_wait[i];
          pos[i]      <= nxt_pos[i];
          bcnt[i]     <= nxt_bcnt[i];
          if (lane_act[i]) begin
            entrada[i*WIDTH +: WIDTH] <= lane_base[i] + WIDTH'(1);
          end else begin
            entrada[i*WIDTH +: WIDTH] <= lane_base[i];
          end
        end
      end else if (finish) begin
        enable  <= 1'b0;
        validin <= '0;
        done    <= 1'b1;
      end
    end
  end

`ifdef PHY_TX_STIM_CHECK_EN
  logic        chk_armed;
  logic [15:0] chk_dly;
  logic        window;

  assign window = chk_armed && (chk_dly == 16'(CHECK_DELAY));

  // Comparator. The window opens CHECK_DELAY cycles after RUN entry, so the
  // two descriptions have time to fill their pipelines. It stays open through
  // DONE. A new RUN entry restarts the delay and clears the results.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      chk_armed      <= 1'b0;
      chk_dly        <= 16'd0;
      mismatch_mask  <= '0;
      mismatch_count <= '0;
    end else if (go) begin
      chk_armed      <= 1'b1;
      chk_dly        <= 16'd0;
      mismatch_mask  <= '0;
      mismatch_count <= '0;
    end else begin
      if (chk_armed && !window) begin
        chk_dly <= chk_dly + 16'd1;
      end
      if (window) begin
        for (int i = 0; i < LANES; i++) begin
          if (ser_a[i] != ser_b[i]) begin
            mismatch_mask[i] <= 1'b1;
            if (mismatch_count[i*16 +: 16] != 16'hFFFF) begin
              mismatch_count[i*16 +: 16] <= mismatch_count[i*16 +: 16] + 16'd1;
            end
          end
        end
      end
    end
  end
`else
  logic unused_cmp;

  assign unused_cmp     = ^{ser_a, ser_b, 16'(CHECK_DELAY)};
  assign mismatch_mask  = '0;
  assign mismatch_count = '0;
`endif

endmodule

// File: tb/tb_phy_tx_stim_gen.sv
`timescale 1ns/1ps
module tb_phy_tx_stim_gen;

  logic        clk_8f = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  ser_a, ser_b;
  logic [3:0]  ser2;

  logic        enable, slot_stb, done;
  logic [1:0]  validin, mismatch_mask;
  logic [15:0] entrada;
  logic [31:0] mismatch_count;

  logic        enable2, slot_stb2, done2;
  logic [3:0]  validin2, mismatch_mask2;
  logic [39:0] entrada2;
  logic [63:0] mismatch_count2;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk_8f = ~clk_8f;

  phy_tx_stim_gen dut (
    .clk_8f(clk_8f), .reset(reset), .start(start), .enable(enable),
    .validin(validin), .entrada(entrada), .slot_stb(slot_stb), .done(done),
    .ser_a(ser_a), .ser_b(ser_b), .mismatch_mask(mismatch_mask),
    .mismatch_count(mismatch_count)
  );

  phy_tx_stim_gen #(.LANES(4), .WIDTH(10), .SKEW(2), .GAP_LEN(0)) dut2 (
    .clk_8f(clk_8f), .reset(reset), .start(start), .enable(enable2),
    .validin(validin2), .entrada(entrada2), .slot_stb(slot_stb2), .done(done2),
    .ser_a(ser2), .ser_b(ser2), .mismatch_mask(mismatch_mask2),
    .mismatch_count(mismatch_count2)
  );

  // One comparator-scenario record: ser_b inversion regions (cycles after RUN
  // entry), optional start pulse during RUN, and expected comparator results.
  typedef struct {
    logic [1:0]  m1;
    int          lo1, hi1;
    logic [1:0]  m2;
    int          lo2, hi2;
    int          start_at;
    logic [15:0] c0, c1;
    logic [1:0]  mask;
  } scen_t;

  typedef struct {
    int          k;
    logic [63:0] valid;
    logic [63:0] data;
  } slot_rec_t;

  scen_t     scen [3];
  slot_rec_t sb1 [$];
  slot_rec_t sb2 [$];

  // Watchdog: the run must end on its own.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit exp_active(int s, int lane, int skew, int blen, int glen, int nb);
    int t;
    t = s - lane * skew;
    if (t < 0) return 1'b0;
    return ((t % (blen + glen)) < blen) && ((t / (blen + glen)) < nb);
  endfunction

  // Expected slot outputs for both DUTs. Slot s is sampled at k = 4s+1 cycles
  // after RUN entry.
  task automatic push_expected();
    slot_rec_t r;
    int cur [4];
    for (int i = 0; i < 2; i++) cur[i] = (i * 239) % 256;
    for (int s = 0; s < 15; s++) begin
      r.k = 4 * s + 1; r.valid = '0; r.data = '0;
      for (int i = 0; i < 2; i++) begin
        if (exp_active(s, i, 1, 4, 3, 2)) begin
          cur[i] = (cur[i] + 1) % 256;
          r.valid[i] = 1'b1;
        end
        r.data[i*8 +: 8] = 8'(cur[i]);
      end
      sb1.push_back(r);
    end
    for (int i = 0; i < 4; i++) cur[i] = (i * 239) % 1024;
    for (int s = 0; s < 14; s++) begin
      r.k = 4 * s + 1; r.valid = '0; r.data = '0;
      for (int i = 0; i < 4; i++) begin
        if (exp_active(s, i, 2, 4, 0, 2)) begin
          cur[i] = (cur[i] + 1) % 1024;
          r.valid[i] = 1'b1;
        end
        r.data[i*10 +: 10] = 10'(cur[i]);
      end
      sb2.push_back(r);
    end
  endtask

  // Pulse start and wait, with a bound, for RUN entry. Returns at the first
  // RUN cycle (k = 0).
  task automatic wait_entry(output bit got);
    int n;
    got = 1'b0; n = 0;
    start = 1'b1;
    while (n < 12 && !got) begin
      @(negedge clk_8f);
      n++;
      start = 1'b0;
      if (enable === 1'b1) got = 1'b1;
    end
    checkOutput("start_latency", (got && n <= 5), 1);
  endtask

  task automatic applyStimulus(input scen_t sc);
    bit got;
    slot_rec_t r;
    logic [31:0] exp_cnt;
    logic [1:0]  exp_mask;
    sb1.delete(); sb2.delete();
    push_expected();
    wait_entry(got);
    if (!got) return;
`ifdef PHY_TX_STIM_CHECK_EN
    exp_cnt = {sc.c1, sc.c0}; exp_mask = sc.mask;
`else
    exp_cnt = '0; exp_mask = '0;
`endif
    for (int k = 0; k <= 70; k++) begin
      if (k > 0) @(negedge clk_8f);
      if (sb1.size() > 0 && sb1[0].k == k) begin
        r = sb1.pop_front();
        checkOutput($sformatf("validin_k%0d", k), 64'(validin), r.valid);
        checkOutput($sformatf("entrada_k%0d", k), 64'(entrada), r.data);
      end
      if (sb2.size() > 0 && sb2[0].k == k) begin
        r = sb2.pop_front();
        checkOutput($sformatf("validin2_k%0d", k), 64'(validin2), r.valid);
        checkOutput($sformatf("entrada2_k%0d", k), 64'(entrada2), r.data);
      end
      if (k < 60) checkOutput($sformatf("slot_stb_k%0d", k), 64'(slot_stb), 64'(k % 4 == 3));
      if (k == 56) begin
        checkOutput("done2_end", 64'(done2), 1);
        checkOutput("validin2_end", 64'(validin2), 0);
      end
      if (k == 59) begin
        checkOutput("done_before_end", 64'(done), 0);
        checkOutput("enable_last_slot", 64'(enable), 1);
      end
      if (k == 60) begin
        checkOutput("done_end", 64'(done), 1);
        checkOutput("enable_end", 64'(enable), 0);
        checkOutput("validin_end", 64'(validin), 0);
        checkOutput("entrada_hold", 64'(entrada), 64'hF708);
      end
      if (k == 61) begin
        checkOutput("mismatch_count", 64'(mismatch_count), 64'(exp_cnt));
        checkOutput("mismatch_mask", 64'(mismatch_mask), 64'(exp_mask));
      end
      if (k == 70) begin
        checkOutput("start_in_run_ignored", 64'(enable), 0);
        checkOutput("done_sticky", 64'(done), 1);
      end
      start = (k == sc.start_at);
      ser_a = (k % 2 == 1) ? 2'b10 : 2'b01;
      ser_b = ser_a;
      if (k >= sc.lo1 && k <= sc.hi1) ser_b = ser_b ^ sc.m1;
      if (k >= sc.lo2 && k <= sc.hi2) ser_b = ser_b ^ sc.m2;
    end
    start = 1'b0;
    ser_b = ser_a;
    checkOutput("scoreboard_drained", 64'(sb1.size() + sb2.size()), 0);
  endtask

  // Reset in slot 2 of a run with start high in the same cycle. Reset must
  // win and the pending start must be dropped.
  task automatic resetMidRun();
    bit got;
    wait_entry(got);
    if (!got) return;
    repeat (9) @(negedge clk_8f);
    reset = 1'b1; start = 1'b1;
    @(negedge clk_8f);
    checkOutput("rst_mid_validin", 64'(validin), 0);
    checkOutput("rst_mid_entrada", 64'(entrada), 64'hEF00);
    checkOutput("rst_mid_done", 64'(done), 0);
    checkOutput("rst_mid_enable", 64'(enable), 0);
    checkOutput("rst_mid_slot_stb", 64'(slot_stb), 0);
    checkOutput("rst_mid_count", 64'(mismatch_count), 0);
    checkOutput("rst_mid_validin2", 64'(validin2), 0);
    reset = 1'b0; start = 1'b0;
    repeat (10) @(negedge clk_8f);
    checkOutput("rst_pending_dropped", 64'(enable), 0);
    checkOutput("rst_pending_dropped2", 64'(enable2), 0);
  endtask

  initial begin
    logic [39:0] seeds2;
    reset = 1'b1; start = 1'b0;
    ser_a = 2'b01; ser_b = 2'b01; ser2 = 4'b0000;

    scen[0] = '{m1: 2'b00, lo1: 0, hi1: -1, m2: 2'b00, lo2: 0, hi2: -1,
                start_at: -1, c0: 16'd0, c1: 16'd0, mask: 2'b00};
    scen[1] = '{m1: 2'b10, lo1: 1, hi1: 3, m2: 2'b10, lo2: 20, hi2: 24,
                start_at: -1, c0: 16'd0, c1: 16'd5, mask: 2'b10};
    scen[2] = '{m1: 2'b01, lo1: 30, hi1: 36, m2: 2'b10, lo2: 50, hi2: 50,
                start_at: 30, c0: 16'd7, c1: 16'd1, mask: 2'b11};

    repeat (2) @(posedge clk_8f);
    @(negedge clk_8f);
    for (int i = 0; i < 4; i++) seeds2[i*10 +: 10] = 10'((i * 239) % 1024);
    checkOutput("reset_enable", 64'(enable), 0);
    checkOutput("reset_validin", 64'(validin), 0);
    checkOutput("reset_entrada", 64'(entrada), 64'hEF00);
    checkOutput("reset_slot_stb", 64'(slot_stb), 0);
    checkOutput("reset_done", 64'(done), 0);
    checkOutput("reset_mask", 64'(mismatch_mask), 0);
    checkOutput("reset_count", 64'(mismatch_count), 0);
    checkOutput("reset_entrada2", 64'(entrada2), 64'(seeds2));
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      $display("[TB] scenario %0d", i);
      applyStimulus(scen[i]);
    end

`ifdef PHY_TX_STIM_CHECK_EN
    ser_a = 2'b00; ser_b = 2'b01;
    repeat (65540) @(negedge clk_8f);
    checkOutput("count_saturate", 64'(mismatch_count[15:0]), 64'hFFFF);
    checkOutput("count_lane1_hold", 64'(mismatch_count[31:16]), 1);
    checkOutput("mask_after_sat", 64'(mismatch_mask), 2'b11);
    ser_b = 2'b00;
`endif

    $display("[TB] reset mid-run");
    resetMidRun();
    $display("[TB] rerun after reset");
    applyStimulus(scen[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/phy_tx_stim_gen.md
# phy_tx_stim_gen

Synthesizable, parametrised N-lane stimulus generator and dual-description lane comparator for the phy_tx path. It derives 2f slot timing from clk_8f and drives per-lane valid/data bursts with configurable length, gap, inter-lane skew and seeds. It compares the serial lane outputs of the conductual and structural phy_tx descriptions bit-for-bit. It replaces hand-sequenced stimulus with a repeatable, parameter-driven schedule usable on bench and FPGA.

## Interface
- LANES, 2, number of lanes (1..8)
- WIDTH, 8, data word width per lane
- BURST_LEN, 4, valid slots per burst (≥1)
- GAP_LEN, 3, idle slots after each burst (≥0)
- NUM_BURSTS, 2, bursts per lane per run (≥1)
- SKEW, 1, slot delay of lane i = i*SKEW
- SEED, 0, lane-0 initial data
- SEED_STEP, 'hEF, lane i seed = SEED + i*SEED_STEP (mod 2^WIDTH)
- CHECK_DELAY, 8, clk_8f cycles after RUN entry before comparison opens
- clk_8f  in  1  fastest clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  run request, level-sampled
- enable  out  1  high while RUN
- validin  out  LANES  per-lane valid, bit i = lane i
- entrada  out  LANES*WIDTH  per-lane data, lane i at [i*WIDTH +: WIDTH]
- slot_stb  out  1  high on last clk_8f cycle of each 2f slot
- done  out  1  schedule complete, sticky until restart/reset
- ser_a  in  LANES  lane serial outputs, conductual description
- ser_b  in  LANES  lane serial outputs, structural description
- mismatch_mask  out  LANES  sticky per-lane mismatch flag
- mismatch_count  out  LANES*16  per-lane saturating mismatch counters, lane i at [i*16 +: 16]

## Operation
- Reset values: enable 0, validin 0, entrada lane i = seed_i, slot_stb 0, done 0, mismatch_mask 0, mismatch_count 0, FSM IDLE, phase 0, start_pending 0.
- 2-bit phase counter free-runs from reset; slot_stb = (phase==3); a slot is 4 clk_8f cycles.
- FSM IDLE: start=1 sets start_pending; on slot_stb with start_pending → RUN, slot index s=0, entrada reloaded to seeds, counters/mask cleared, done 0.
- RUN: lane i active in slot s when t = s − i*SKEW ≥ 0, t mod (BURST_LEN+GAP_LEN) < BURST_LEN, t/(BURST_LEN+GAP_LEN) < NUM_BURSTS. Per-lane position/burst counters; no divider.
- Active slot: validin[i]=1 and entrada lane i = previous value + 1 (wraps mod 2^WIDTH); inactive slot: validin[i]=0, entrada holds.
- Last slot = NUM_BURSTS*(BURST_LEN+GAP_LEN) + (LANES−1)*SKEW − 1; on its slot_stb → DONE: enable 0, validin 0, done 1, entrada holds.
- DONE: start=1 sets start_pending; next slot_stb → RUN as above. start in RUN ignored.
- Comparator: window opens CHECK_DELAY cycles after RUN entry, closes on leaving DONE/reset. Each cycle in window, ser_a[i]≠ser_b[i] → count i +1 (saturate 16'hFFFF), mask[i] set.

## Timing
- All outputs registered; slot outputs change on the edge where slot_stb=1, visible the next 4 cycles.
- start to first validin: ≤5 cycles (pending wait up to 4, plus register).
- Comparator: mismatch sampled at edge N → count/mask updated after edge N.
- Reset asserted mid-run: all outputs at reset values after that edge; pending start dropped; phase restarts at 0.
- start and reset same cycle: reset wins.
- Counter at 16'hFFFF with new mismatch: holds 16'hFFFF.

## Configuration
- PHY_TX_STIM_CHECK_EN defined: comparator, mismatch_mask and mismatch_count built as above.
- Undefined: comparator removed; mismatch_mask and mismatch_count constant 0; ser_a/ser_b unused; stimulus unchanged.

## Test plan
- Defaults, reset 2 cycles, start pulse → lane0 valid slots 0–3 data 01..04, slots 7–10 data 05..08; lane1 valid slots 1–4 F0..F3, slots 8–11 F4..F7; done after slot 14, i.e. 60 cycles after RUN entry.
- ser_a=ser_b=alternating pattern throughout run → mismatch_count all 0, mask 2'b00, done 1.
- Invert ser_b[1] for 5 cycles inside window, plus 3 cycles before CHECK_DELAY → count lane1=5, lane0=0, mask 2'b10.
- Reset asserted in slot 2 of run → next cycle validin 0, entrada {EF,00}, done 0; new start reproduces test 1 exactly.
- LANES=4, WIDTH=10, SKEW=2, GAP_LEN=0 → lane3 first valid slot 6, seed 3*EF mod 1024 = 0x2CD, first word 0x2CE; continuous 4-word bursts.
- PHY_TX_STIM_CHECK_EN undefined, ser_b forced ≠ ser_a → mismatch outputs stay 0, stimulus identical to test 1.
